// File: rtl/alu_ctrl_seq.sv
`timescale 1ns/1ps
// alu_ctrl_seq: registered MIPS ALU control with a fixed-latency mul/div
// sequencer. Decodes ALUOp/funct into ALUSignal one cycle after accept.
// Build option: define ALU_MULDIV_EN to enable mult/multu/div/divu and
// mfhi/mflo. Without it those functs decode as illegal, the unit never
// stalls, and md_start/md_op/hilo_we are tied low.
//
// Handshake: an instruction is accepted on a rising edge when
// in_valid && in_ready && !flush; in_ready is combinational and only high in
// IDLE with rst_n high. Each accept yields exactly one out_valid pulse
// (one cycle later for single-cycle ops, MUL_CYCLES/DIV_CYCLES later for
// mul/div), unless flush or reset abandons the op first.
module alu_ctrl_seq #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        funct,
    input  logic              flush,
    output logic [CTRL_W-1:0] ALUSignal,
    output logic              out_valid,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              hilo_we
);

    localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

    // Reject parameter sets the sequencer cannot represent.
    if (CTRL_W < 4 || MUL_CYCLES < 2 || DIV_CYCLES < 2 ||
        (MAX_N - 1) >= (1 << CNT_W)) begin : g_bad_params
        $error("alu_ctrl_seq: unsupported parameter combination");
    end

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;
`endif
    localparam logic [3:0] OP_NOP  = 4'b1111;

    logic [3:0]        dec_code;
    logic              dec_ill;
    logic              accept;
    logic [CTRL_W-1:0] sig_q;
    logic              ov_q;
    logic              ill_q;

`ifdef ALU_MULDIV_EN
    logic       dec_md;
    logic [1:0] dec_mdop;
`endif

    // Instruction decode: ALU code, illegal flag and mul/div selection.
    always_comb begin
        dec_code = OP_NOP;
        dec_ill  = 1'b0;
`ifdef ALU_MULDIV_EN
        dec_md   = 1'b0;
        dec_mdop = 2'b00;
`endif
        case (ALUOp)
            2'b00: dec_code = OP_ADD;
            2'b01: dec_code = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b000000: dec_code = OP_SLL;
                    6'b000010: dec_code = OP_SRL;
                    6'b000011: dec_code = OP_SRA;
                    6'b100000,
                    6'b100001: dec_code = OP_ADD;
                    6'b100010,
                    6'b100011: dec_code = OP_SUB;
                    6'b100100: dec_code = OP_AND;
                    6'b100101: dec_code = OP_OR;
                    6'b100110: dec_code = OP_XOR;
                    6'b100111: dec_code = OP_NOR;
                    6'b101010: dec_code = OP_SLT;
                    6'b101011: dec_code = OP_SLTU;
`ifdef ALU_MULDIV_EN
                    6'b010000: dec_code = OP_MFHI;
                    6'b010010: dec_code = OP_MFLO;
                    // funct[1:0] maps straight onto md_op: mult, multu, div, divu.
                    6'b011000,
                    6'b011001,
                    6'b011010,
                    6'b011011: begin
                        dec_md   = 1'b1;
                        dec_mdop = funct[1:0];
                    end
`endif
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] sig_d;
    logic              ov_d, ill_d;
    logic              mds_q, mds_d;
    logic [1:0]        mdop_q, mdop_d;
    logic              hwe_q, hwe_d;

    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready && !flush;

    // Next-state and next-output logic; outputs are pulses unless noted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        ov_d    = 1'b0;
        ill_d   = 1'b0;
        mds_d   = 1'b0;
        mdop_d  = mdop_q;
        hwe_d   = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                if (dec_md) begin
                    state_d = BUSY;
                    cnt_d   = dec_mdop[1] ? DIV_LOAD : MUL_LOAD;
                    mds_d   = 1'b1;
                    mdop_d  = dec_mdop;
                end else begin
                    ov_d  = 1'b1;
                    ill_d = dec_ill;
                    sig_d = CTRL_W'(dec_code);
                end
            end
        end else begin
            if (flush) begin
                // Abandon the op silently; md_op keeps its last value.
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                cnt_d   = '0;
                hwe_d   = 1'b1;
                ov_d    = 1'b1;
                sig_d   = CTRL_W'(OP_NOP);
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
            ov_q    <= 1'b0;
            ill_q   <= 1'b0;
            mds_q   <= 1'b0;
            mdop_q  <= 2'b00;
            hwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            ov_q    <= ov_d;
            ill_q   <= ill_d;
            mds_q   <= mds_d;
            mdop_q  <= mdop_d;
            hwe_q   <= hwe_d;
        end
    end

    assign md_start = mds_q;
    assign md_op    = mdop_q;
    assign hilo_we  = hwe_q;
`else
    assign in_ready = rst_n;
    assign accept   = in_valid && in_ready && !flush;

    // Single-cycle decode register; ALUSignal holds between results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
            ov_q  <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            ov_q  <= accept;
            ill_q <= accept && dec_ill;
            if (accept) begin
                sig_q <= CTRL_W'(dec_code);
            end
        end
    end

    assign md_start = 1'b0;
    assign md_op    = 2'b00;
    assign hilo_we  = 1'b0;
`endif

    assign ALUSignal = sig_q;
    assign out_valid = ov_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
`timescale 1ns/1ps
// tb_alu_ctrl_seq: directed plus randomized stimulus, reference model built
// from the opcode table and a "free again at cycle X" view of the sequencer,
// scoreboard queues popped by a negedge monitor.
module tb_alu_ctrl_seq;
  localparam int CTRL_W = 4;
  localparam int MUL_N  = 4;
  localparam int DIV_N  = 33;
  localparam int W      = 38;  // {cycle[31:0], hilo, illegal, code[3:0]}

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ALUOp;
  logic [5:0]        funct;
  logic              flush;
  logic [CTRL_W-1:0] ALUSignal;
  logic              out_valid;
  logic              illegal;
  logic              md_start;
  logic [1:0]        md_op;
  logic              hilo_we;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .CTRL_W(CTRL_W),
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ALUOp(ALUOp),
    .funct(funct),
    .flush(flush),
    .ALUSignal(ALUSignal),
    .out_valid(out_valid),
    .illegal(illegal),
    .md_start(md_start),
    .md_op(md_op),
    .hilo_we(hilo_we)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;           // cycle number; increments at each rising edge
  int ready_cycle = 0;   // first cycle in which the unit accepts again
  logic last_rst = 1'b0; // rst_n was low at the most recent edge
  int tab[64];           // -1 illegal, 0..15 ALU code, 16+op mul/div
  int legal_f[20];
  int n_legal = 0;

  logic [W-1:0]  exp_q[$];
  logic [33:0]   md_q[$];  // {cycle[31:0], md_op}

  function automatic void add_op(input int f, input int v);
    tab[f] = v;
    legal_f[n_legal] = f;
    n_legal++;
  endfunction

  function automatic void init_table();
    for (int i = 0; i < 64; i++) tab[i] = -1;
    add_op('h00, 8);  add_op('h02, 9);  add_op('h03, 10);
    add_op('h20, 2);  add_op('h21, 2);  add_op('h22, 6);  add_op('h23, 6);
    add_op('h24, 0);  add_op('h25, 1);  add_op('h26, 3);  add_op('h27, 12);
    add_op('h2a, 7);  add_op('h2b, 11);
`ifdef ALU_MULDIV_EN
    add_op('h10, 13); add_op('h12, 14);
    add_op('h18, 16); add_op('h19, 17); add_op('h1a, 18); add_op('h1b, 19);
`endif
  endfunction

  function automatic int ref_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 2;
    if (op == 2'b01) return 6;
    if (op == 2'b11) return -1;
    return tab[f];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: decide accepts from the rules and push expected responses.
  always @(posedge clk) begin
    int r;
    int n;
    last_rst = !rst_n;
    if (!rst_n) begin
      exp_q.delete();
      md_q.delete();
      ready_cycle = cyc + 1;
    end else if (in_valid && !flush && cyc >= ready_cycle) begin
      r = ref_decode(ALUOp, funct);
      if (r >= 16) begin
        n = (r - 16 >= 2) ? DIV_N : MUL_N;
        ready_cycle = cyc + n;
        exp_q.push_back({32'(cyc + n), 1'b1, 1'b0, 4'hF});
        md_q.push_back({32'(cyc + 1), 2'(r - 16)});
      end else if (r < 0) begin
        exp_q.push_back({32'(cyc + 1), 1'b0, 1'b1, 4'hF});
      end else begin
        exp_q.push_back({32'(cyc + 1), 1'b0, 1'b0, 4'(r)});
      end
    end else if (flush && cyc < ready_cycle) begin
      // mul/div in flight is dropped: its completion never appears
      if (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1][37:6]) > cyc)
        void'(exp_q.pop_back());
      ready_cycle = cyc + 1;
    end
    cyc++;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [3:0] m_sig = 4'h0;
  logic [1:0] m_mdop = 2'b00;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [33:0]  m;
    if (cyc >= 1) begin
      if (last_rst) begin
        m_sig = 4'h0;
        m_mdop = 2'b00;
      end
      chk("in_ready", 32'(in_ready), 32'(rst_n && cyc >= ready_cycle));
      while (exp_q.size() > 0 && int'(exp_q[0][37:6]) < cyc) begin
        e = exp_q.pop_front();
        chk("missed_result", 32'(0), 32'(1));
      end
      if (exp_q.size() > 0 && int'(exp_q[0][37:6]) == cyc) begin
        e = exp_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(1));
        chk("illegal", 32'(illegal), 32'(e[4]));
        chk("hilo_we", 32'(hilo_we), 32'(e[5]));
        m_sig = e[3:0];
      end else begin
        chk("idle_out_valid", 32'(out_valid), 32'(0));
        chk("idle_illegal", 32'(illegal), 32'(0));
        chk("idle_hilo_we", 32'(hilo_we), 32'(0));
      end
      chk("ALUSignal", 32'(ALUSignal), 32'(m_sig));
      while (md_q.size() > 0 && int'(md_q[0][33:2]) < cyc) begin
        m = md_q.pop_front();
        chk("missed_md_start", 32'(0), 32'(1));
      end
      if (md_q.size() > 0 && int'(md_q[0][33:2]) == cyc) begin
        m = md_q.pop_front();
        chk("md_start", 32'(md_start), 32'(1));
        m_mdop = m[1:0];
      end else begin
        chk("idle_md_start", 32'(md_start), 32'(0));
      end
      chk("md_op", 32'(md_op), 32'(m_mdop));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
    in_valid = v;
    ALUOp    = op;
    funct    = f;
    flush    = fl;
  endtask

  // Present an instruction until the unit is ready, bounded.
  task automatic issue_wait(input logic [1:0] op, input logic [5:0] f);
    logic done;
    done = 1'b0;
    drive(1'b1, op, f, 1'b0);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("issue_wait_timeout", 32'(done), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] dir_op[8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
  logic [5:0] dir_f[8]  = '{6'h20, 6'h03, 6'h27, 6'h2b, 6'h00, 6'h00, 6'h00, 6'h3f};

  initial begin
    init_table();
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 6'h20, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 6'h00, 1'b0);
    step();

    // back-to-back single-cycle ops, then illegal forms
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, dir_op[i], dir_f[i], 1'b0);
      step();
    end
    drive(1'b0, 2'b00, 6'h00, 1'b0);
    step();

    // mult followed by an mflo that must wait out the interlock
    drive(1'b1, 2'b10, 6'h18, 1'b0);
    step();
    issue_wait(2'b10, 6'h12);
    repeat (3) step();

    // divu flushed ten cycles after accept
    drive(1'b1, 2'b10, 6'h1b, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (35) step();

    // flush in idle blocks the accept
    drive(1'b1, 2'b00, 6'h00, 1'b1);
    step();
    drive(1'b0, 2'b00, 6'h00, 1'b0);
    step();

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      logic [5:0] f;
      if ($urandom_range(0, 3) != 0) f = 6'(legal_f[$urandom_range(0, n_legal - 1)]);
      else f = 6'($urandom_range(0, 63));
      rst_n = ($urandom_range(0, 149) != 0);
      drive(1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 4) != 0) ? 2'b10 : 2'($urandom_range(0, 3)),
            f,
            1'($urandom_range(0, 19) == 0));
      step();
    end
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 6'h00, 1'b0);
    repeat (40) step();

    chk("drain_exp_q", 32'(exp_q.size()), 32'(0));
    chk("drain_md_q", 32'(md_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU control unit with a multi-cycle multiply/divide sequencer for the MIPS datapath.
- Decodes ALUOp/funct into a registered ALUSignal and extends the R-type set (sra, xor, nor, sltu, addu/subu, mfhi/mflo).
- Runs mult/multu/div/divu as fixed-latency operations and stalls issue through a valid/ready handshake until HI/LO are written.
- Sits between the decode/issue stage and the ALU plus external mul/div datapath.

Parameters:
CTRL_W, 4, ALUSignal width; must be >= 4; upper bits above [3:0] driven 0
MUL_CYCLES, 4, mult/multu latency N in cycles, accept to done; must be >= 2
DIV_CYCLES, 33, div/divu latency N in cycles; must be >= 2
CNT_W, 6, busy counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising clk
in_valid  input  1  instruction presented
in_ready  output  1  combinational: state==IDLE && rst_n
ALUOp  input  2  main-control ALU class
funct  input  6  R-type funct field
flush  input  1  synchronous pipeline flush
ALUSignal  output  CTRL_W  registered ALU operation code
out_valid  output  1  one-cycle pulse: ALUSignal valid for accepted instruction
illegal  output  1  one-cycle pulse with out_valid for undecodable input
md_start  output  1  one-cycle pulse launching mul/div datapath
md_op  output  2  00 mult, 01 multu, 10 div, 11 divu; held while BUSY
hilo_we  output  1  one-cycle pulse writing HI/LO at mul/div completion

Behaviour:
- Accept = in_valid && in_ready && !flush, sampled at the rising edge ending cycle t.
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, all registered outputs 0 (ALUSignal=0, out_valid/illegal/md_start/hilo_we=0, md_op=00). Any operation in flight is abandoned with no hilo_we.
- Decode:
  - ALUOp 00 -> 0010 (add). ALUOp 01 -> 0110 (sub). ALUOp 11 -> illegal.
  - ALUOp 10, funct decode: 000000 sll 1000; 000010 srl 1001; 000011 sra 1010; 100000/100001 add/addu 0010; 100010/100011 sub/subu 0110; 100100 and 0000; 100101 or 0001; 100110 xor 0011; 100111 nor 1100; 101010 slt 0111; 101011 sltu 1011; 010000 mfhi 1101; 010010 mflo 1110.
  - ALUOp 10, mul/div funct: 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - Any other funct -> illegal.
- Single-cycle op accepted in cycle t:
  - ALUSignal=code and out_valid=1 in cycle t+1.
  - State stays IDLE, so back-to-back accepts give one result per cycle.
  - ALUSignal holds its last value when out_valid=0.
- Illegal op accepted in cycle t: in cycle t+1, out_valid=1, illegal=1, ALUSignal=all-ones (NOP). State stays IDLE.
- Mul/div op accepted in cycle t, with N = MUL_CYCLES or DIV_CYCLES:
  - Cycle t+1: state=BUSY, counter=N-1, md_start=1, md_op set.
  - Each BUSY edge decrements the counter.
  - When the counter reaches 1 at an edge, the next cycle (t+N) shows hilo_we=1, out_valid=1, ALUSignal=all-ones, state=IDLE.
  - in_ready is therefore low for cycles t+1..t+N-1 and high again in t+N.
  - An mfhi/mflo presented during BUSY waits (interlock).
- flush:
  - In IDLE: blocks the accept that cycle; no out_valid next cycle.
  - In BUSY: state->IDLE, counter=0 at that edge; no hilo_we or out_valid for the abandoned op. md_op holds its last value.
  - flush together with in_valid: flush wins.
- Reset overrides flush and in_valid.

Optional Feature:
- ALU_MULDIV_EN defined: mul/div sequencer, BUSY state, md_start/md_op/hilo_we behave as above; mfhi/mflo decode legally.
- ALU_MULDIV_EN undefined:
  - Funct 011000-011011, 010000 and 010010 decode as illegal.
  - No BUSY state; in_ready = rst_n.
  - md_start, md_op and hilo_we are tied to 0. Ports remain present.

Test Plan:
- Reset: hold rst_n=0 two edges with in_valid=1 -> all outputs 0, in_ready=0. Release -> in_ready=1.
- Back-to-back: ALUOp=10 with funct 100000, 000011, 100111, 101011 on consecutive cycles -> out_valid each next cycle, ALUSignal 0010, 1010, 1100, 1011. ALUOp=00 -> 0010; ALUOp=01 -> 0110.
- Illegal: ALUOp=11; then ALUOp=10 with funct 111111 -> each: out_valid=1, illegal=1, ALUSignal=1111 next cycle.
- Mult (MUL_CYCLES=4), accept at t:
  - md_start and md_op=00 at t+1; in_ready=0 for t+1..t+3.
  - An mflo held valid from t+1 is not accepted until t+4.
  - hilo_we=1 and out_valid=1 at t+4; the mflo is accepted at t+4 and gives ALUSignal=1110 at t+5.
- Flush mid-div (DIV_CYCLES=33): accept divu at t, flush at t+10 -> in_ready=1 at t+11, no hilo_we through t+40.
- Flush in IDLE: flush=1 with in_valid=1 -> not accepted, no out_valid next cycle.
- Build without ALU_MULDIV_EN: funct 011010 -> illegal=1, md_start stays 0, in_ready stays 1.
